// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// The pipeline side uses the master modport; the hazard controller uses slave.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              id_valid;
   logic              id_is_halt;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_wr_en;
   logic              ex_is_load;
   logic              ex_branch_taken;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_wr_en;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_wr_en;

   logic              stall_if_id;
   logic              bubble_ex;
   logic              flush_if_id;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_w_cnt;
   logic [CNT_W-1:0]  stall_wo_cnt;
   logic              halted;

   modport master (
      output id_valid, id_is_halt, id_rs, id_rt, id_use_rs, id_use_rt,
             ex_rs, ex_rt, ex_rd, ex_wr_en, ex_is_load, ex_branch_taken,
             mem_rd, mem_wr_en, wb_rd, wb_wr_en,
      input  stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel,
             stall_w_cnt, stall_wo_cnt, halted
   );

   modport slave (
      input  id_valid, id_is_halt, id_rs, id_rt, id_use_rs, id_use_rt,
             ex_rs, ex_rt, ex_rd, ex_wr_en, ex_is_load, ex_branch_taken,
             mem_rd, mem_wr_en, wb_rd, wb_wr_en,
      output stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel,
             stall_w_cnt, stall_wo_cnt, halted
   );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW hazard detection, forwarding selects, halt drain and stall accounting for the 5-stage core.
// Define HAZ_FORWARD_EN to enable EX-stage forwarding; otherwise stalls follow the no-forwarding model.
module hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int BR_PENALTY   = 2
) (
   input logic         clk,
   input logic         reset,
   hazard_ctrl_if.slave hz
);
   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             seen_q;
   logic [CNT_W-1:0] stall_w_q, stall_w_d;
   logic [CNT_W-1:0] stall_wo_q, stall_wo_d;

   logic dep_ex, dep_mem, hazard_stall;
   logic stall, bubble, flush, halted, branch_flush, do_count;
   logic [1:0] fwd_a, fwd_b;

   // Register 0 is hardwired to zero, so it never produces a dependency.
   function automatic logic writes_to(input logic wr_en, input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] idx);
      return wr_en && (rd != '0) && (rd == idx);
   endfunction

   assign dep_ex  = (hz.id_use_rs && writes_to(hz.ex_wr_en, hz.ex_rd, hz.id_rs)) ||
                    (hz.id_use_rt && writes_to(hz.ex_wr_en, hz.ex_rd, hz.id_rt));
   assign dep_mem = (hz.id_use_rs && writes_to(hz.mem_wr_en, hz.mem_rd, hz.id_rs)) ||
                    (hz.id_use_rt && writes_to(hz.mem_wr_en, hz.mem_rd, hz.id_rt));

`ifdef HAZ_FORWARD_EN
   assign hazard_stall = hz.id_valid && dep_ex && hz.ex_is_load;
   // EX/MEM result is younger than MEM/WB, so it wins when both match.
   assign fwd_a = writes_to(hz.mem_wr_en, hz.mem_rd, hz.ex_rs) ? 2'b01 :
                  (writes_to(hz.wb_wr_en, hz.wb_rd, hz.ex_rs) ? 2'b10 : 2'b00);
   assign fwd_b = writes_to(hz.mem_wr_en, hz.mem_rd, hz.ex_rt) ? 2'b01 :
                  (writes_to(hz.wb_wr_en, hz.wb_rd, hz.ex_rt) ? 2'b10 : 2'b00);
`else
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{hz.ex_rs, hz.ex_rt, hz.wb_rd, hz.wb_wr_en};
   // Without forwarding the consumer waits until the producer reaches WB.
   assign hazard_stall = hz.id_valid && (dep_ex || dep_mem);
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d      = state_q;
      drain_d      = drain_q;
      stall        = 1'b0;
      bubble       = 1'b0;
      flush        = 1'b0;
      halted       = 1'b0;
      branch_flush = 1'b0;
      unique case (state_q)
         RUN: begin
            if (hz.ex_branch_taken) begin
               flush        = 1'b1;
               bubble       = 1'b1;
               branch_flush = 1'b1;
            end else begin
               if (hazard_stall) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end
               if (hz.id_valid && hz.id_is_halt) begin
                  state_d = DRAIN;
                  drain_d = DW'(DRAIN_CYCLES);
               end
            end
         end
         DRAIN: begin
            // Only in the first drain cycle can an older taken branch still squash the halt.
            if (hz.ex_branch_taken && (drain_q == DW'(DRAIN_CYCLES))) begin
               state_d      = RUN;
               flush        = 1'b1;
               bubble       = 1'b1;
               branch_flush = 1'b1;
            end else begin
               stall   = 1'b1;
               bubble  = 1'b1;
               drain_d = drain_q - DW'(1);
               if (drain_q <= DW'(1)) state_d = HALTED;
            end
         end
         HALTED: begin
            halted = 1'b1;
            stall  = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // Each ID instruction is charged once, on its first cycle; held cycles are free.
   assign do_count = (state_q == RUN) && hz.id_valid && !hz.ex_branch_taken && !seen_q;

   always_comb begin
      stall_w_d  = stall_w_q;
      stall_wo_d = stall_wo_q;
      if (branch_flush) begin
         stall_w_d  = stall_w_q  + CNT_W'(BR_PENALTY);
         stall_wo_d = stall_wo_q + CNT_W'(BR_PENALTY);
      end else if (do_count) begin
         if (dep_ex && hz.ex_is_load) stall_w_d = stall_w_q + CNT_W'(1);
         if (dep_ex)                  stall_wo_d = stall_wo_q + CNT_W'(2);
         else if (dep_mem)            stall_wo_d = stall_wo_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         drain_q    <= '0;
         seen_q     <= 1'b0;
         stall_w_q  <= '0;
         stall_wo_q <= '0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         seen_q     <= stall;
         stall_w_q  <= stall_w_d;
         stall_wo_q <= stall_wo_d;
      end
   end

   assign hz.stall_if_id  = stall  && !reset;
   assign hz.bubble_ex    = bubble && !reset;
   assign hz.flush_if_id  = flush  && !reset;
   assign hz.halted       = halted && !reset;
   assign hz.fwd_a_sel    = reset ? 2'b00 : fwd_a;
   assign hz.fwd_b_sel    = reset ? 2'b00 : fwd_b;
   assign hz.stall_w_cnt  = stall_w_q;
   assign hz.stall_wo_cnt = stall_wo_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage (IF/ID/EX/MEM/WB) 32-register processor core.
- Detects RAW data hazards and generates the control outputs: stall, bubble and flush for the IF/ID/EX stage registers, and EX-stage operand forwarding selects.
- Sequences the halt drain (opcode 6'b010001).
- Maintains the stall-with-forwarding and stall-without-forwarding counters that the top-level timing report consumes.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 32, width of the stall counters.
- DRAIN_CYCLES, 3, cycles after halt leaves ID before halted asserts (EX, MEM, WB retire).
- BR_PENALTY, 2, cycles added to both counters per taken branch.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_is_halt  in  1  ID instruction opcode == 6'b010001.
- id_rs  in  REG_AW  ID source A index.
- id_rt  in  REG_AW  ID source B index.
- id_use_rs  in  1  ID reads rs.
- id_use_rt  in  1  ID reads rt.
- ex_rs  in  REG_AW  EX source A index.
- ex_rt  in  REG_AW  EX source B index.
- ex_rd  in  REG_AW  EX destination.
- ex_wr_en  in  1  EX writes a register.
- ex_is_load  in  1  EX is a load.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_rd  in  REG_AW  MEM destination.
- mem_wr_en  in  1  MEM writes a register.
- wb_rd  in  REG_AW  WB destination.
- wb_wr_en  in  1  WB writes a register.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- fwd_a_sel  out  2  EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b_sel  out  2  EX operand B: same encoding as fwd_a_sel.
- stall_w_cnt  out  CNT_W  stall cycles, forwarding model.
- stall_wo_cnt  out  CNT_W  stall cycles, no-forwarding model.
- halted  out  1  pipeline drained after halt.

Behaviour:
- Reset:
  - All outputs 0; counters 0; FSM = RUN.
  - The "seen" flag is cleared.
  - Reset mid-DRAIN or in HALTED returns to RUN.
- Register index 0 never creates a hazard and never forwards.
- depEX / depMEM definitions:
  - depEX = ex_wr_en && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
  - depMEM is the same expression using mem_rd / mem_wr_en.
- Outputs are combinational from inputs and state; counters and state are registered.
- Forwarding (combinational):
  - fwd_a_sel = 01 if mem_wr_en && mem_rd!=0 && mem_rd==ex_rs.
  - else 10 if wb_wr_en && wb_rd!=0 && wb_rd==ex_rs.
  - else 00. fwd_b_sel is the same using ex_rt.
  - EX/MEM has priority over MEM/WB.
- Load-use stall:
  - Condition: RUN && id_valid && depEX && ex_is_load.
  - Response: stall_if_id=1 and bubble_ex=1 for exactly 1 cycle.
- Taken branch:
  - ex_branch_taken -> flush_if_id=1 and bubble_ex=1 for 1 cycle.
  - Overrides load-use stall: stall_if_id=0 that cycle.
  - Both counters += BR_PENALTY.
- Counting, once per ID instruction:
  - The registered flag "seen" is set while the same instruction is held in ID by a stall.
  - On the first ID cycle with id_valid, no branch flush, and FSM=RUN:
    - stall_w_cnt += (depEX && ex_is_load) ? 1 : 0.
    - stall_wo_cnt += depEX ? 2 : (depMEM ? 1 : 0).
  - The regfile is write-first in WB, so a WB dependency costs 0.
  - A held (seen) cycle adds nothing.
  - Counters wrap modulo 2^CNT_W.
- FSM:
  - RUN -> DRAIN on id_valid && id_is_halt && !ex_branch_taken.
  - DRAIN:
    - stall_if_id=1 and bubble_ex=1 each cycle.
    - A down-counter loads DRAIN_CYCLES on entry.
    - At 0, go to HALTED.
    - ex_branch_taken during the first DRAIN cycle (older branch squashes the halt) -> RUN, with flush applied.
  - HALTED: halted=1 and stall_if_id=1 permanently until reset; counters frozen.
- Halt in ID with a simultaneous load-use: enter DRAIN; stall_w_cnt still counts the load-use cycle.

Optional Feature:
- HAZ_FORWARD_EN defined:
  - Forwarding as above.
  - Actual stalls follow the forwarding model (load-use only).
- HAZ_FORWARD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - Actual stalls follow the no-forwarding model: depEX -> 2 stall cycles, else depMEM -> 1 stall cycle.
  - Both counters keep identical accounting in both builds, so the top-level report is unchanged.

Test Plan:
- Load-use:
  - Stimulus: ex_is_load, ex_rd=5, ex_wr_en; ID id_rs=5, id_use_rs.
  - Response: stall_if_id=bubble_ex=1 for one cycle.
  - Counters: stall_w_cnt 0->1, stall_wo_cnt 0->2, no double count on the held cycle.
- Forwarding priority:
  - Stimulus: ex_rs=3, mem_rd=3 and wb_rd=3, both wr_en.
  - Response: fwd_a_sel=01.
  - Then mem_wr_en=0 -> fwd_a_sel=10.
  - Then ex_rs=0 with mem_rd=0 -> fwd_a_sel=00.
- ALU dependency:
  - Stimulus: ex_is_load=0, ex_rd=7 matching id_rt with id_use_rt.
  - Response: no stall; stall_w_cnt +0, stall_wo_cnt +2.
  - Repeat with mem_rd=7 only -> stall_wo_cnt +1.
- Branch vs load-use:
  - Stimulus: ex_branch_taken together with a load-use condition.
  - Response: flush_if_id=1, bubble_ex=1, stall_if_id=0; both counters +2.
- Halt drain:
  - Stimulus: id_is_halt with id_valid.
  - Response: stall_if_id=bubble_ex=1 for 3 cycles, then halted=1 and held.
  - Counters frozen afterwards; reset returns halted to 0.
- Squashed halt:
  - Stimulus: halt in ID with ex_branch_taken in the same cycle.
  - Response: FSM stays RUN, halted stays 0, flush_if_id=1.
